// File: rtl/mx_dot_stream_if.sv
// Beat/result handshake bundle for mx_dot_stream: element vectors and block
// scales in, scaled dot-product mantissa out.
interface mx_dot_stream_if #(
  parameter int C         = 256,
  parameter int k         = 32,
  parameter int bit_width = 8,
  parameter int out_width = 8
);
  logic                         i_valid;
  logic                         o_ready;
  logic [C-1:0][bit_width-1:0]  i_X;
  logic [C-1:0][bit_width-1:0]  i_Y;
  logic [C/k-1:0][7:0]          i_S;
  logic [C/k-1:0][7:0]          i_T;
  logic                         o_valid;
  logic                         i_ready;
  logic signed [out_width-1:0]  o_dp;
  logic [7:0]                   o_scale;

  modport slave  (input  i_valid, i_X, i_Y, i_S, i_T, i_ready,
                  output o_ready, o_valid, o_dp, o_scale);
  modport master (output i_valid, i_X, i_Y, i_S, i_T, i_ready,
                  input  o_ready, o_valid, o_dp, o_scale);
endinterface

// File: rtl/mx_dot_stream.sv
// Streaming MX-format dot product: per-block exact dot products, a registered
// normalising add tree across blocks, then accumulation over N_BEATS beats.
module mx_dot_stream #(
  parameter int C         = 256,
  parameter int k         = 32,
  parameter int bit_width = 8,
  parameter int out_width = 8,
  parameter int N_BEATS   = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  mx_dot_stream_if.slave  bus
);
  localparam int NB         = C / k;
  localparam int dp_width   = 2*bit_width + $clog2(k);
  localparam int tree_depth = $clog2(NB);
  localparam int CW         = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;

  localparam logic signed [dp_width-1:0] SMAX = dp_width'((2**(out_width-1)) - 1);
  localparam logic signed [dp_width-1:0] SMIN = dp_width'(-(2**(out_width-1)));

  typedef struct packed {
    logic signed [dp_width-1:0] dp;
    logic [7:0]                 sc;
  } mx_t;

  // Shifts past the full width collapse to the sign, regardless of amount.
  function automatic logic signed [dp_width-1:0] ashr(input logic signed [dp_width-1:0] v,
                                                      input logic [7:0] d);
    if (int'(d) >= dp_width) ashr = {dp_width{v[dp_width-1]}};
    else                     ashr = v >>> d;
  endfunction

  function automatic mx_t nadd(input mx_t a, input mx_t b);
    logic signed [dp_width-1:0] ma, mb;
    logic signed [dp_width:0]   sum;
    mx_t r;
    if (a.sc >= b.sc) begin
      r.sc = a.sc;
      ma   = a.dp;
      mb   = ashr(b.dp, a.sc - b.sc);
    end else begin
      r.sc = b.sc;
      ma   = ashr(a.dp, b.sc - a.sc);
      mb   = b.dp;
    end
    sum = $signed({ma[dp_width-1], ma}) + $signed({mb[dp_width-1], mb});
    if (sum[dp_width] != sum[dp_width-1]) begin
      r.dp = sum[dp_width:1];
      r.sc = r.sc + 8'd1;
    end else begin
      r.dp = sum[dp_width-1:0];
    end
    return r;
  endfunction

  logic                        en;
  logic [CW-1:0]               cnt_q;
  logic                        last_beat, first_beat;
  logic [tree_depth+2:0]       vld_pipe_q, last_pipe_q;
  logic [tree_depth+1:0]       first_pipe_q;
  logic [C-1:0][bit_width-1:0] x0_q, y0_q;
  logic [NB-1:0][7:0]          s0_q, t0_q;
  mx_t                         lvl_q [tree_depth+1][NB];
  mx_t                         lvl_d [tree_depth+1][NB];
  mx_t                         acc_q, acc_d;
  logic signed [out_width-1:0] o_dp_q, o_dp_d;
  logic [7:0]                  o_scale_q;
  logic                        o_valid_q;

  assign en         = !(o_valid_q && !bus.i_ready);
  assign last_beat  = (cnt_q == CW'(N_BEATS-1));
  assign first_beat = (cnt_q == '0);

  // Level 0 is the per-block dot product; level l pairs entries of level l-1.
  always_comb begin
    logic signed [dp_width-1:0]    dsum;
    logic signed [2*bit_width-1:0] prod;
    dsum = '0;
    prod = '0;
    for (int l = 0; l <= tree_depth; l++)
      for (int j = 0; j < NB; j++)
        lvl_d[l][j] = '0;
    for (int i = 0; i < NB; i++) begin
      dsum = '0;
      for (int j = 0; j < k; j++) begin
        prod = $signed(x0_q[i*k+j]) * $signed(y0_q[i*k+j]);
        dsum = dsum + dp_width'(prod);
      end
      lvl_d[0][i].dp = dsum;
      lvl_d[0][i].sc = s0_q[i] + t0_q[i];
    end
    for (int l = 1; l <= tree_depth; l++)
      for (int j = 0; j < (NB >> l); j++)
        lvl_d[l][j] = nadd(lvl_q[l-1][2*j], lvl_q[l-1][2*j+1]);
  end

  always_comb begin
    acc_d = first_pipe_q[tree_depth+1] ? lvl_q[tree_depth][0]
                                       : nadd(acc_q, lvl_q[tree_depth][0]);
    if ($signed(acc_q.dp) > SMAX)      o_dp_d = SMAX[out_width-1:0];
    else if ($signed(acc_q.dp) < SMIN) o_dp_d = SMIN[out_width-1:0];
    else                               o_dp_d = acc_q.dp[out_width-1:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_pipe_q <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      o_valid_q  <= 1'b0;
      o_dp_q     <= '0;
      o_scale_q  <= '0;
    end else if (en) begin
      vld_pipe_q   <= {vld_pipe_q[tree_depth+1:0], bus.i_valid};
      last_pipe_q  <= {last_pipe_q[tree_depth+1:0], last_beat};
      first_pipe_q <= {first_pipe_q[tree_depth:0], first_beat};
      x0_q         <= bus.i_X;
      y0_q         <= bus.i_Y;
      s0_q         <= bus.i_S;
      t0_q         <= bus.i_T;
      lvl_q        <= lvl_d;
      if (bus.i_valid) cnt_q <= last_beat ? '0 : cnt_q + 1'b1;
      if (vld_pipe_q[tree_depth+1]) acc_q <= acc_d;
      o_valid_q <= vld_pipe_q[tree_depth+2] && last_pipe_q[tree_depth+2];
      if (vld_pipe_q[tree_depth+2] && last_pipe_q[tree_depth+2]) begin
        o_dp_q    <= o_dp_d;
        o_scale_q <= acc_q.sc;
      end
    end
  end

  assign bus.o_ready = en;
  assign bus.o_valid = o_valid_q;
  assign bus.o_dp    = o_dp_q;
  assign bus.o_scale = o_scale_q;
endmodule

// File: tb/tb_mx_dot_stream.sv
// Directed-vector bench for mx_dot_stream (C=4, k=2, N_BEATS=2) with a
// queue scoreboard checked by an independent output monitor.
module tb_mx_dot_stream;
  localparam int C = 4, K = 2, BW = 8, OW = 8, NBT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mx_dot_stream_if #(.C(C), .k(K), .bit_width(BW), .out_width(OW)) bus ();

  mx_dot_stream #(.C(C), .k(K), .bit_width(BW), .out_width(OW), .N_BEATS(NBT)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct { int dp; int sc; } exp_t;
  exp_t sb[$];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input int dp, input int sc);
    exp_t e;
    e.dp = dp;
    e.sc = sc;
    sb.push_back(e);
  endtask

  // Present one beat (same X/Y on every element) and hold until accepted.
  task automatic send(input int xv, input int yv, input int s0, input int s1,
                      input int t0, input int t1);
    int n;
    for (int e = 0; e < C; e++) begin
      bus.i_X[e] = 8'(xv);
      bus.i_Y[e] = 8'(yv);
    end
    bus.i_S[0] = 8'(s0);
    bus.i_S[1] = 8'(s1);
    bus.i_T[0] = 8'(t0);
    bus.i_T[1] = 8'(t1);
    bus.i_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.o_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.o_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: o_ready stayed %0d, expected 1", bus.o_ready);
      bus.i_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 bus.i_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1 chk("drain_pending", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.o_valid && bus.i_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_out: got dp %0d scale %0d, expected no result",
                 bus.o_dp, bus.o_scale);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_dp", bus.o_dp, e.dp);
        chk("out_scale", bus.o_scale, e.sc);
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    bus.i_X = '0;
    bus.i_Y = '0;
    bus.i_S = '0;
    bus.i_T = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_ready", bus.o_ready, 1);
    chk("rst_dp", bus.o_dp, 0);
    chk("rst_scale", bus.o_scale, 0);

    // Basic vector plus latency: last beat at edge t, o_valid after t+4.
    push(8, 0);
    send(1, 1, 0, 0, 0, 0);
    send(1, 1, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 chk("lat_early", bus.o_valid, 0);
    @(posedge clk);
    #1 chk("lat_t4", bus.o_valid, 1);

    // Back-to-back vectors covering scale alignment, overflow and saturation.
    push(2, 2);     send(1, 1, 2, 0, 0, 0);        send(0, 0, 0, 0, 0, 0);
    push(127, 1);   send(127, 127, 0, 0, 0, 0);    send(127, 127, 0, 0, 0, 0);
    push(-128, 1);  send(127, -128, 0, 0, 0, 0);   send(127, -128, 0, 0, 0, 0);
    push(8, 44);    send(1, 1, 200, 200, 100, 100); send(1, 1, 200, 200, 100, 100);
    push(48, 0);    send(2, 3, 0, 0, 0, 0);        send(2, 3, 0, 0, 0, 0);
    push(-40, 0);   send(-1, 5, 0, 0, 0, 0);       send(-1, 5, 0, 0, 0, 0);
    push(18, 1);    send(1, 1, 0, 0, 0, 0);        send(2, 2, 1, 1, 0, 0);
    push(3, 200);   send(-1, 1, 0, 0, 0, 0);       send(1, 1, 100, 100, 100, 100);
    drain();

    // Downstream stall with more beats queued behind the held result.
    bus.i_ready = 1'b0;
    push(8, 0);
    push(72, 0);
    send(1, 1, 0, 0, 0, 0);
    send(1, 1, 0, 0, 0, 0);
    fork
      begin
        send(3, 3, 0, 0, 0, 0);
        send(3, 3, 0, 0, 0, 0);
      end
      begin
        n = 0;
        @(negedge clk);
        while (!bus.o_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        for (int i = 0; i < 5; i++) begin
          chk("stall_valid", bus.o_valid, 1);
          chk("stall_ready", bus.o_ready, 0);
          chk("stall_dp", bus.o_dp, 8);
          chk("stall_scale", bus.o_scale, 0);
          @(negedge clk);
        end
        @(posedge clk);
        #1 bus.i_ready = 1'b1;
      end
    join
    drain();

    // Reset after beat 0 must drop the partial vector.
    send(5, 5, 0, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midrst_ready", bus.o_ready, 1);
    chk("midrst_valid", bus.o_valid, 0);
    push(8, 0);
    send(1, 1, 0, 0, 0, 0);
    send(1, 1, 0, 0, 0, 0);
    drain();
    repeat (10) @(posedge clk);
    #1 chk("idle_valid", bus.o_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
